// File: rtl/dyn_addr_table_pkg.sv
// Shared types for the I3C dynamic-address manager: address CCC events,
// completion codes, the controller state and the reserved-address constants.
package dyn_addr_table_pkg;

  typedef enum logic [1:0] {
    EVT_RSTDAA   = 2'd0,
    EVT_SETDASA  = 2'd1,
    EVT_SETNEWDA = 2'd2,
    EVT_SETAASA  = 2'd3
  } addr_evt_e;

  typedef enum logic [1:0] {
    ERR_OK        = 2'd0,
    ERR_COLLISION = 2'd1,
    ERR_BAD_STATE = 2'd2,
    ERR_RESERVED  = 2'd3
  } addr_err_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SCAN   = 3'd1,
    ST_COMMIT = 3'd2,
    ST_APPLY  = 3'd3,
    ST_DONE   = 3'd4
  } dat_state_e;

  localparam logic [6:0] I3cBroadcastAddr = 7'h7E;
  localparam logic [6:0] I3cAddrZero      = 7'h00;

endpackage

// File: rtl/dyn_addr_table.sv
// Dynamic-address table for the main and virtual I3C targets: validates address
// CCCs, scans for collisions, commits into the table and strobes the CSR hwif.
//
// state  | meaning
// IDLE   | ready for an address event
// SCAN   | walk all devices looking for a colliding dynamic address
// COMMIT | write the directed address and strobe its CSR update
// APPLY  | broadcast walk (RSTDAA / SETAASA), one device per cycle
// DONE   | one-cycle completion pulse with the result code
module dyn_addr_table
  import dyn_addr_table_pkg::*;
#(
  parameter int unsigned NumDevices  = 2,
  parameter int unsigned AddrWidth   = 7,
  parameter int unsigned DevIdxWidth = (NumDevices > 1) ? $clog2(NumDevices) : 1
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic                            evt_valid_i,
  output logic                            evt_ready_o,
  input  logic [1:0]                      evt_type_i,
  input  logic [DevIdxWidth-1:0]          evt_dev_i,
  input  logic [AddrWidth-1:0]            evt_addr_i,
  input  logic [NumDevices*AddrWidth-1:0] static_addr_i,
  input  logic [NumDevices-1:0]           static_addr_valid_i,
  output logic [NumDevices*AddrWidth-1:0] dyn_addr_o,
  output logic [NumDevices-1:0]           dyn_addr_valid_o,
  output logic                            upd_valid_o,
  output logic [DevIdxWidth-1:0]          upd_dev_o,
  output logic [AddrWidth-1:0]            upd_addr_o,
  output logic                            upd_addr_valid_o,
  output logic                            done_o,
  output logic [1:0]                      err_o
);

  localparam logic [DevIdxWidth-1:0] LastIdx = DevIdxWidth'(NumDevices - 1);

  dat_state_e                           state_q, state_d;
  logic [DevIdxWidth-1:0]               idx_q, idx_d;
  logic                                 coll_q, coll_d;
  addr_evt_e                            type_q, type_d;
  logic [DevIdxWidth-1:0]               dev_q, dev_d;
  logic [AddrWidth-1:0]                 addr_q, addr_d;
  logic                                 ready_q, ready_d;
  logic                                 upd_valid_q, upd_valid_d;
  logic [DevIdxWidth-1:0]               upd_dev_q, upd_dev_d;
  logic [AddrWidth-1:0]                 upd_addr_q, upd_addr_d;
  logic                                 upd_av_q, upd_av_d;
  logic                                 done_q, done_d;
  addr_err_e                            err_q, err_d;
  logic [NumDevices-1:0][AddrWidth-1:0] dyn_q;
  logic [NumDevices-1:0]                valid_q;

  logic [NumDevices-1:0][AddrWidth-1:0] static_addr;
  addr_evt_e                            evt_type;
  logic                                 dev_in_range, dev_cur_valid, addr_reserved, scan_hit;
  logic                                 ap_go;
  logic [DevIdxWidth-1:0]               ap_idx;
  addr_evt_e                            ap_type;

  assign static_addr   = static_addr_i;
  assign evt_type      = addr_evt_e'(evt_type_i);
  assign dev_in_range  = 32'(evt_dev_i) < NumDevices;
  assign dev_cur_valid = dev_in_range && valid_q[evt_dev_i];
  assign addr_reserved = (evt_addr_i == AddrWidth'(I3cBroadcastAddr)) ||
                         (evt_addr_i == AddrWidth'(I3cAddrZero));
  assign scan_hit      = (idx_q != dev_q) && valid_q[idx_q] && (dyn_q[idx_q] == addr_q);

  // Update strobes are prepared one edge early so every hwif output is a flop.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    coll_d      = coll_q;
    type_d      = type_q;
    dev_d       = dev_q;
    addr_d      = addr_q;
    upd_valid_d = 1'b0;
    upd_dev_d   = upd_dev_q;
    upd_addr_d  = upd_addr_q;
    upd_av_d    = upd_av_q;
    done_d      = 1'b0;
    err_d       = err_q;
    ap_go       = 1'b0;
    ap_idx      = '0;
    ap_type     = type_q;

    unique case (state_q)
      ST_IDLE: begin
        if (evt_valid_i && ready_q) begin
          type_d = evt_type;
          dev_d  = evt_dev_i;
          addr_d = evt_addr_i;
          coll_d = 1'b0;
          idx_d  = '0;
          if (evt_type == EVT_RSTDAA || evt_type == EVT_SETAASA) begin
            state_d = ST_APPLY;
            ap_go   = 1'b1;
            ap_type = evt_type;
          end else if (addr_reserved) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
            err_d   = ERR_RESERVED;
          end else if (!dev_in_range ||
                       (evt_type == EVT_SETDASA && dev_cur_valid) ||
                       (evt_type == EVT_SETNEWDA && !dev_cur_valid)) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
            err_d   = ERR_BAD_STATE;
          end else begin
            state_d = ST_SCAN;
          end
        end
      end
      ST_SCAN: begin
        coll_d = coll_q | scan_hit;
        if (idx_q == LastIdx) begin
          if (coll_d) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
            err_d   = ERR_COLLISION;
          end else begin
            state_d     = ST_COMMIT;
            upd_valid_d = 1'b1;
            upd_dev_d   = dev_q;
            upd_addr_d  = addr_q;
            upd_av_d    = 1'b1;
          end
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      ST_COMMIT: begin
        state_d = ST_DONE;
        done_d  = 1'b1;
        err_d   = ERR_OK;
      end
      ST_APPLY: begin
        if (idx_q == LastIdx) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
          err_d   = ERR_OK;
        end else begin
          idx_d  = idx_q + 1'b1;
          ap_go  = 1'b1;
          ap_idx = idx_q + 1'b1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    if (ap_go) begin
      upd_dev_d = ap_idx;
      if (ap_type == EVT_RSTDAA) begin
        upd_valid_d = 1'b1;
        upd_addr_d  = '0;
        upd_av_d    = 1'b0;
      end else if (static_addr_valid_i[ap_idx] && !valid_q[ap_idx]) begin
        upd_valid_d = 1'b1;
        upd_addr_d  = static_addr[ap_idx];
        upd_av_d    = 1'b1;
      end
    end

    ready_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      coll_q      <= 1'b0;
      type_q      <= EVT_RSTDAA;
      dev_q       <= '0;
      addr_q      <= '0;
      ready_q     <= 1'b0;
      upd_valid_q <= 1'b0;
      upd_dev_q   <= '0;
      upd_addr_q  <= '0;
      upd_av_q    <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= ERR_OK;
      dyn_q       <= '0;
      valid_q     <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      coll_q      <= coll_d;
      type_q      <= type_d;
      dev_q       <= dev_d;
      addr_q      <= addr_d;
      ready_q     <= ready_d;
      upd_valid_q <= upd_valid_d;
      upd_dev_q   <= upd_dev_d;
      upd_addr_q  <= upd_addr_d;
      upd_av_q    <= upd_av_d;
      done_q      <= done_d;
      err_q       <= err_d;
      // The table follows the strobe on the edge that ends the strobe cycle.
      if (upd_valid_q) begin
        dyn_q[upd_dev_q]   <= upd_addr_q;
        valid_q[upd_dev_q] <= upd_av_q;
      end
    end
  end

  assign evt_ready_o      = ready_q;
  assign dyn_addr_o       = dyn_q;
  assign dyn_addr_valid_o = valid_q;
  assign upd_valid_o      = upd_valid_q;
  assign upd_dev_o        = upd_dev_q;
  assign upd_addr_o       = upd_addr_q;
  assign upd_addr_valid_o = upd_av_q;
  assign done_o           = done_q;
  assign err_o            = err_q;

endmodule

// File: tb/tb_dyn_addr_table.sv
// Self-checking bench for dyn_addr_table: directed scenarios plus random address
// CCCs compared against an event-level model of the address table.
module tb_dyn_addr_table;

  localparam int N  = 2;
  localparam int AW = 7;
  localparam int DW = 1;

  logic            clk_i = 1'b0;
  logic            rst_i = 1'b1;
  logic            evt_valid_i = 1'b0;
  logic            evt_ready_o;
  logic [1:0]      evt_type_i = '0;
  logic [DW-1:0]   evt_dev_i = '0;
  logic [AW-1:0]   evt_addr_i = '0;
  logic [N*AW-1:0] static_addr_i;
  logic [N-1:0]    static_addr_valid_i;
  logic [N*AW-1:0] dyn_addr_o;
  logic [N-1:0]    dyn_addr_valid_o;
  logic            upd_valid_o;
  logic [DW-1:0]   upd_dev_o;
  logic [AW-1:0]   upd_addr_o;
  logic            upd_addr_valid_o;
  logic            done_o;
  logic [1:0]      err_o;

  dyn_addr_table #(.NumDevices(N), .AddrWidth(AW)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .evt_valid_i(evt_valid_i), .evt_ready_o(evt_ready_o),
    .evt_type_i(evt_type_i), .evt_dev_i(evt_dev_i), .evt_addr_i(evt_addr_i),
    .static_addr_i(static_addr_i), .static_addr_valid_i(static_addr_valid_i),
    .dyn_addr_o(dyn_addr_o), .dyn_addr_valid_o(dyn_addr_valid_o),
    .upd_valid_o(upd_valid_o), .upd_dev_o(upd_dev_o), .upd_addr_o(upd_addr_o),
    .upd_addr_valid_o(upd_addr_valid_o), .done_o(done_o), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    int         cyc;
    int         dev;
    logic [6:0] addr;
    logic       av;
  } strobe_t;

  int checks = 0;
  int errors = 0;

  // Reference state: what the table should hold and the current static CSR view.
  logic [6:0] m_a [N];
  logic       m_v [N];
  logic [6:0] s_a [N];
  logic       s_v [N];

  strobe_t    exp_q[$];
  strobe_t    obs_q[$];
  int         exp_done;
  logic [1:0] exp_err;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      static_addr_i[i*AW +: AW] = s_a[i];
      static_addr_valid_i[i]    = s_v[i];
    end
  end

  function automatic void model_reset();
    for (int i = 0; i < N; i++) begin
      m_a[i] = '0;
      m_v[i] = 1'b0;
    end
  endfunction

  // Outcome of one event from the CCC rules; cycles counted from the handshake.
  function automatic void model_event(input logic [1:0] t, input int dev, input logic [6:0] a);
    bit coll;
    exp_q.delete();
    exp_err = 2'd0;
    if (t == 2'd0 || t == 2'd3) begin
      for (int i = 0; i < N; i++) begin
        if (t == 2'd0) begin
          exp_q.push_back('{i + 1, i, 7'h00, 1'b0});
          m_a[i] = 7'h00;
          m_v[i] = 1'b0;
        end else if (s_v[i] && !m_v[i]) begin
          exp_q.push_back('{i + 1, i, s_a[i], 1'b1});
          m_a[i] = s_a[i];
          m_v[i] = 1'b1;
        end
      end
      exp_done = N + 1;
    end else if (a == 7'h7E || a == 7'h00) begin
      exp_done = 1;
      exp_err  = 2'd3;
    end else if ((t == 2'd1 && m_v[dev]) || (t == 2'd2 && !m_v[dev])) begin
      exp_done = 1;
      exp_err  = 2'd2;
    end else begin
      coll = 1'b0;
      for (int j = 0; j < N; j++)
        if (j != dev && m_v[j] && m_a[j] == a) coll = 1'b1;
      if (coll) begin
        exp_done = N + 1;
        exp_err  = 2'd1;
      end else begin
        exp_q.push_back('{N + 1, dev, a, 1'b1});
        exp_done = N + 2;
        m_a[dev] = a;
        m_v[dev] = 1'b1;
      end
    end
  endfunction

  // Runs from just after the handshake edge until done, then checks the table.
  task automatic collect(input string nm);
    int         odone;
    logic [1:0] oerr;
    int         n;
    odone = -1;
    oerr  = 2'd0;
    obs_q.delete();
    for (int c = 1; c <= N + 6 && odone < 0; c++) begin
      @(negedge clk_i);
      if (c == 1) evt_valid_i = 1'b0;
      if (upd_valid_o === 1'b1)
        obs_q.push_back('{c, int'(upd_dev_o), upd_addr_o, upd_addr_valid_o});
      if (done_o === 1'b1) begin
        odone = c;
        oerr  = err_o;
      end
    end
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL %s strobe_count: got %0d want %0d", nm, obs_q.size(), exp_q.size());
    end
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int k = 0; k < n; k++) begin
      checks++;
      if (obs_q[k].cyc != exp_q[k].cyc || obs_q[k].dev != exp_q[k].dev ||
          obs_q[k].addr !== exp_q[k].addr || obs_q[k].av !== exp_q[k].av) begin
        errors++;
        $display("FAIL %s strobe%0d: got cyc%0d dev%0d %h/%b want cyc%0d dev%0d %h/%b", nm, k,
                 obs_q[k].cyc, obs_q[k].dev, obs_q[k].addr, obs_q[k].av,
                 exp_q[k].cyc, exp_q[k].dev, exp_q[k].addr, exp_q[k].av);
      end
    end
    checks++;
    if (odone != exp_done) begin
      errors++;
      $display("FAIL %s done_cycle: got %0d want %0d (-1 = timeout)", nm, odone, exp_done);
    end
    checks++;
    if (oerr !== exp_err) begin
      errors++;
      $display("FAIL %s err: got %0d want %0d", nm, oerr, exp_err);
    end
    @(negedge clk_i);
    checks++;
    if (evt_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL %s ready_after_done: got %b want 1", nm, evt_ready_o);
    end
    for (int i = 0; i < N; i++) begin
      checks++;
      if (dyn_addr_valid_o[i] !== m_v[i] || dyn_addr_o[i*AW +: AW] !== m_a[i]) begin
        errors++;
        $display("FAIL %s table%0d: got %h/%b want %h/%b", nm, i,
                 dyn_addr_o[i*AW +: AW], dyn_addr_valid_o[i], m_a[i], m_v[i]);
      end
    end
  endtask

  task automatic run_event(input logic [1:0] t, input int dev, input logic [6:0] a, input string nm);
    model_event(t, dev, a);
    @(negedge clk_i);
    evt_valid_i = 1'b1;
    evt_type_i  = t;
    evt_dev_i   = dev[DW-1:0];
    evt_addr_i  = a;
    checks++;
    if (evt_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL %s ready: got %b want 1", nm, evt_ready_o);
    end
    @(posedge clk_i);
    collect(nm);
  endtask

  task automatic check_all_zero(input string nm);
    checks++;
    if ({evt_ready_o, upd_valid_o, done_o, err_o, dyn_addr_o, dyn_addr_valid_o} !== '0) begin
      errors++;
      $display("FAIL %s outputs_zero: got rdy%b upd%b done%b err%0d dyn%h val%b want all 0", nm,
               evt_ready_o, upd_valid_o, done_o, err_o, dyn_addr_o, dyn_addr_valid_o);
    end
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    repeat (2) @(negedge clk_i);
    check_all_zero("reset");
    rst_i = 1'b0;
    model_reset();
    @(negedge clk_i);
    checks++;
    if (evt_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL reset_release ready: got %b want 1", evt_ready_o);
    end
  endtask

  task automatic test_directed();
    s_a[0] = 7'h50; s_a[1] = 7'h51;
    s_v[0] = 1'b0;  s_v[1] = 1'b1;
    run_event(2'd1, 0, 7'h12, "setdasa_dev0");
    run_event(2'd1, 1, 7'h12, "setdasa_collision");
    run_event(2'd2, 1, 7'h20, "setnewda_badstate");
    run_event(2'd1, 1, 7'h34, "setdasa_dev1");
    run_event(2'd0, 0, 7'h00, "rstdaa");
    run_event(2'd3, 0, 7'h00, "setaasa");
    run_event(2'd1, 0, 7'h7E, "setdasa_reserved");
    run_event(2'd1, 1, 7'h00, "setdasa_zero");
  endtask

  task automatic test_back_to_back();
    run_event(2'd0, 0, 7'h00, "b2b_rstdaa");
    run_event(2'd1, 0, 7'h22, "b2b_setdasa");
    model_event(2'd2, 0, 7'h23);
    @(negedge clk_i);
    evt_valid_i = 1'b1;
    evt_type_i  = 2'd2;
    evt_dev_i   = '0;
    evt_addr_i  = 7'h23;
    @(posedge clk_i);
    for (int c = 1; c <= N + 2; c++) begin
      @(negedge clk_i);
      checks++;
      if (evt_ready_o !== 1'b0) begin
        errors++;
        $display("FAIL b2b busy_ready c%0d: got %b want 0", c, evt_ready_o);
      end
      checks++;
      if (done_o !== (c == exp_done)) begin
        errors++;
        $display("FAIL b2b first_done c%0d: got %b want %b", c, done_o, c == exp_done);
      end
    end
    @(negedge clk_i);
    checks++;
    if (evt_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL b2b ready_after_done: got %b want 1", evt_ready_o);
    end
    model_event(2'd2, 0, 7'h23);
    @(posedge clk_i);
    collect("b2b_second");
  endtask

  task automatic test_reset_mid_scan();
    run_event(2'd0, 0, 7'h00, "mid_rstdaa");
    run_event(2'd1, 0, 7'h11, "mid_setdasa0");
    @(negedge clk_i);
    evt_valid_i = 1'b1;
    evt_type_i  = 2'd1;
    evt_dev_i   = 1'b1;
    evt_addr_i  = 7'h40;
    @(posedge clk_i);
    @(negedge clk_i);
    evt_valid_i = 1'b0;
    rst_i = 1'b1;
    #1;
    check_all_zero("mid_scan_reset");
    model_reset();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk_i);
      checks++;
      if (done_o !== 1'b0) begin
        errors++;
        $display("FAIL mid_scan_reset done c%0d: got %b want 0", c, done_o);
      end
    end
    rst_i = 1'b0;
    @(negedge clk_i);
    run_event(2'd1, 1, 7'h40, "after_reset_setdasa");
  endtask

  task automatic test_random();
    logic [6:0] pool [8];
    logic [1:0] t;
    int         dev;
    logic [6:0] a;
    pool[0] = 7'h00; pool[1] = 7'h7E; pool[2] = 7'h12; pool[3] = 7'h20;
    pool[4] = 7'h34; pool[5] = 7'h50; pool[6] = 7'h51; pool[7] = 7'h12;
    for (int e = 0; e < 60; e++) begin
      for (int i = 0; i < N; i++) begin
        s_a[i] = pool[$urandom_range(2, 7)];
        s_v[i] = $urandom_range(0, 1) == 1;
      end
      t = 2'($urandom_range(0, 3));
      if (t == 2'd0 && $urandom_range(0, 2) != 0) t = 2'd1;
      dev = $urandom_range(0, N - 1);
      a   = ($urandom_range(0, 3) == 0) ? 7'($urandom_range(1, 125)) : pool[$urandom_range(0, 7)];
      run_event(t, dev, a, $sformatf("rand%0d_t%0d", e, t));
    end
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      s_a[i] = '0;
      s_v[i] = 1'b0;
    end
    model_reset();
    test_reset();
    test_directed();
    test_back_to_back();
    test_reset_mid_scan();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dyn_addr_table.md
Name: dyn_addr_table

Overview:
- Parametrised dynamic-address manager for NumDevices I3C target identities (main target plus virtual targets). It replaces fixed main/virtual address muxing.
- It accepts address CCC events (RSTDAA, SETDASA, SETNEWDA, SETAASA) over a valid/ready handshake and validates them against device state. It checks for address collisions across devices, and then commits the result into a registered address table.
- It emits per-device update strobes that drive the CSR hwif we/next fields of the standby-controller device-address registers. It sits between the CCC decoder and the CSR block.

Parameters:
- NumDevices, 2, number of target identities; index 0 is the main target, 1..N-1 are virtual targets; range 1..8.
- AddrWidth, 7, I3C address width.
- DevIdxWidth, $clog2(NumDevices) clamped to at least 1, device index width.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset, asynchronous, active-high.
- evt_valid_i  in  1  address event valid.
- evt_ready_o  out  1  event accepted when valid&ready.
- evt_type_i  in  2  addr_evt_e: 0 RSTDAA, 1 SETDASA, 2 SETNEWDA, 3 SETAASA.
- evt_dev_i  in  DevIdxWidth  target device; used by SETDASA and SETNEWDA only.
- evt_addr_i  in  AddrWidth  new address; used by SETDASA and SETNEWDA only.
- static_addr_i  in  NumDevices*AddrWidth  per-device static address from CSR.
- static_addr_valid_i  in  NumDevices  per-device static address valid.
- dyn_addr_o  out  NumDevices*AddrWidth  registered dynamic address table.
- dyn_addr_valid_o  out  NumDevices  per-device dynamic address valid.
- upd_valid_o  out  1  one-cycle CSR update strobe (maps to hwif .we).
- upd_dev_o  out  DevIdxWidth  device index being updated.
- upd_addr_o  out  AddrWidth  new DYNAMIC_ADDR.next.
- upd_addr_valid_o  out  1  new DYNAMIC_ADDR_VALID.next.
- done_o  out  1  one-cycle pulse when an event completes.
- err_o  out  2  addr_err_e, valid with done_o: 0 OK, 1 COLLISION, 2 BAD_STATE, 3 RESERVED.

Behaviour:
- Reset (async, rst_i=1):
  - Table is cleared: all dyn_addr=0, all valid=0.
  - FSM goes to IDLE; scan index=0.
  - upd_valid_o=0, done_o=0, err_o=0, evt_ready_o=0 while in reset.
  - Reset mid-operation aborts the event with no done_o.
- FSM states: IDLE, SCAN, COMMIT, APPLY, DONE.
- evt_ready_o=1 only in IDLE. On handshake, type, dev, and addr are latched. Inputs are ignored outside the handshake.
- IDLE, on RSTDAA or SETAASA: go to APPLY with idx=0.
- IDLE, on SETDASA or SETNEWDA, checks are made on the accept cycle:
  - addr equal to 7'h7E or 7'h00 → DONE with err=RESERVED.
  - SETDASA on a device that already has valid=1 → DONE with err=BAD_STATE.
  - SETNEWDA on a device with valid=0 → DONE with err=BAD_STATE.
  - Otherwise go to SCAN with idx=0.
- SCAN: one device per cycle, idx 0..N-1.
  - A collision is flagged if idx≠dev, valid[idx]=1, and dyn_addr[idx]==addr. The flag is sticky.
  - After idx=N-1: collision → DONE with err=COLLISION; else → COMMIT.
- COMMIT (1 cycle):
  - table[dev] is set to (addr, 1).
  - upd_valid_o=1 with upd_dev=dev, upd_addr=addr, upd_addr_valid=1.
  - Next state is DONE.
- APPLY: one device per cycle, idx 0..N-1, with one upd strobe per affected device.
  - RSTDAA: every device is cleared to (0, 0) and strobed, including devices already invalid.
  - SETAASA: only devices with static_valid=1 and valid=0 are loaded with (static_addr, 1) and strobed. Other devices get no strobe in their cycle.
  - SETAASA does not check for collisions.
  - After idx=N-1 → DONE.
- DONE (1 cycle): done_o=1 with err_o; then → IDLE.
- Latency, measured from the handshake cycle:
  - SETDASA or SETNEWDA success: upd at cycle N+1, done at N+2.
  - Early error: done at cycle 1.
  - Broadcast: strobes at cycles 1..N, done at N+1.
- Back-to-back: the next event can be accepted in the cycle after DONE. A held evt_valid_i stays stalled while the FSM is busy.
- dyn_addr_o and dyn_addr_valid_o are updated on the same edge that ends the strobe cycle. Readers see the new value the cycle after upd_valid_o.
- Scan uses the table value at each idx cycle. The table cannot change during a scan because only one event is in flight.
- NumDevices=1: SCAN takes one cycle and can never flag a collision.

Decomposition:
- Add to i3c_pkg:
  - addr_evt_e (2-bit).
  - addr_err_e (2-bit).
  - I3cBroadcastAddr=7'h7E.
  - I3cAddrZero=7'h00.
- No sub-module: the FSM, scan counter, and table live in one module of roughly 200 lines.
- csri instantiates dyn_addr_table and maps upd_* onto the StdbyCtrlMode device-address hwif fields:
  - dev 0 → STBY_CR_DEVICE_ADDR.
  - dev 1 → STBY_CR_VIRT_DEVICE_ADDR.

Test Plan:
- N=2: SETDASA dev0 addr 0x12 → upd strobe (0, 0x12, 1) at cycle 3; done, err=0 at cycle 4; dyn_addr[0]=0x12 and valid[0]=1.
- After the above, SETDASA dev1 addr 0x12 → done at cycle 3 with err=COLLISION, no upd strobe, dev1 still invalid. Then SETNEWDA dev1 addr 0x20 → done with err=BAD_STATE at cycle 1.
- With dev0=0x12 and dev1=0x34 valid, RSTDAA → strobes (0,0,0) then (1,0,0) on consecutive cycles, done at cycle 3, all valid=0.
- static={0x50,0x51}, static_valid=2'b10, all invalid, SETAASA → one strobe (1, 0x51, 1) at cycle 2, done at cycle 3, dev0 untouched.
- SETDASA dev0 addr 0x7E → done at cycle 1, err=RESERVED. evt_valid held during a busy SETNEWDA → evt_ready_o=0 until the cycle after DONE.
- Assert rst_i during SCAN → all outputs are 0 asynchronously, no done_o, and the next event after release is accepted normally.
